// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage controllers: stage-mode codes,
// controller FSM encoding and small elaboration-time helpers.
package fft_pkg;

  // Stage mode presented to the butterfly for the current beat
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BFLY  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Controller sequencing states (FILL/BFLY are decoded from the counter)
  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_STREAM = 2'd1,
    FSM_DRAIN  = 2'd2
  } fsm_e;

  // Ceiling log2 for parameter derivation
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Twiddle index step between consecutive butterfly beats of a stage
  function automatic int tw_stride(input int n_points, input int delay);
    return n_points / (2 * delay);
  endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// Wrapping beat counter shared by all SDF stage controllers.
// Clear has priority over enable; wrap is the natural CW-bit rollover.
module fft_beat_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, advance on a beat, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF FFT stage. Mode, twiddle address
// and output-valid are combinational decodes that describe the beat happening
// in the same cycle; after a legally placed in_last the delay line is drained.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINTS = 256,
  parameter int DELAY    = 8,
  parameter int TW_AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [1:0]       state,
  output logic [TW_AW-1:0] tw_addr,
  output logic             out_valid,
  output logic             frame_done,
  output logic             err_last
);

  localparam int            CW            = clog2(2 * DELAY);
  localparam int            TW_STRIDE     = tw_stride(N_POINTS, DELAY);
  localparam logic [CW-1:0] CNT_LAST      = CW'(2 * DELAY - 1);
  localparam logic [CW-1:0] CNT_DRAIN_END = CW'(DELAY - 1);

  fsm_e             fsm_q, fsm_d;
  logic             primed_q, primed_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt;
  logic             cnt_en;
  logic             cnt_clr;
  logic             bfly_half;
  logic [TW_AW-1:0] tw_bfly;

  fft_beat_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .cnt_o (cnt)
  );

  // Upper half of the 2D window is the butterfly half
  assign bfly_half = cnt[CW-1];

  generate
    if (DELAY > 1) begin : g_tw
      assign tw_bfly = TW_AW'(32'(cnt[CW-2:0]) * TW_STRIDE);
    end else begin : g_tw_single
      assign tw_bfly = '0;
    end
  endgenerate

  // Next-state and per-beat decode; idle cycles without a beat report IDLE
  always_comb begin
    fsm_d     = fsm_q;
    primed_d  = primed_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    in_ready  = 1'b1;
    state     = ST_IDLE;
    tw_addr   = '0;
    out_valid = 1'b0;
    case (fsm_q)
      FSM_DRAIN: begin
        in_ready  = 1'b0;
        state     = ST_DRAIN;
        out_valid = 1'b1;
        cnt_en    = 1'b1;
        if (cnt == CNT_DRAIN_END) begin
          fsm_d    = FSM_IDLE;
          cnt_clr  = 1'b1;
          primed_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        if (in_valid) begin
          state     = bfly_half ? ST_BFLY : ST_FILL;
          tw_addr   = bfly_half ? tw_bfly : '0;
          out_valid = primed_q || bfly_half;
          cnt_en    = 1'b1;
          fsm_d     = FSM_STREAM;
          if (bfly_half) primed_d = 1'b1;
          if (in_last) begin
            if (cnt == CNT_LAST) begin
              fsm_d   = FSM_DRAIN;
              cnt_clr = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // Controller state, priming flag, sticky error and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= FSM_IDLE;
      primed_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      primed_q <= primed_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign err_last   = err_q;
  assign frame_done = done_q;

endmodule
